// File: rtl/f1_lights_ctrl_if.sv
// Lamp/delay-counter bus of the F1 start-light controller.
// master = controller side, slave = clktick / delay counter / lamp driver side.
interface f1_lights_ctrl_if #(
   parameter int N_LIGHTS = 8,
   parameter int DELAY_W  = 7
);
   logic                en;
   logic                trigger;
   logic                delay_done;
   logic [N_LIGHTS-1:0] data_out;
   logic                cmd_seq;
   logic                cmd_delay;
   logic [DELAY_W-1:0]  delay_k;
   logic                lights_out;
   logic                busy;

   modport master (
      input  en, trigger, delay_done,
      output data_out, cmd_seq, cmd_delay, delay_k, lights_out, busy
   );

   modport slave (
      output en, trigger, delay_done,
      input  data_out, cmd_seq, cmd_delay, delay_k, lights_out, busy
   );
endinterface

// File: rtl/f1_lights_ctrl.sv
// F1 start lights: trigger edge -> one lamp per en tick -> all-on for an LFSR-random delay -> lights out.
// Latency: first lamp on the first en after the registered trigger edge; delay_done to dark is 1 cycle.
// Backpressure: none; en paces FILL, the external delay counter paces HOLD via cmd_delay/delay_done.
module f1_lights_ctrl #(
   parameter int                 N_LIGHTS     = 8,
   parameter int                 DELAY_W      = 7,
   parameter logic [DELAY_W-1:0] LFSR_TAPS    = 7'h44,
   parameter logic [DELAY_W-1:0] LFSR_SEED    = 7'h01,
   parameter bit                 AUTO_RESTART = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   f1_lights_ctrl_if.master    bus
);
   localparam int CNT_W = $clog2(N_LIGHTS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_LIGHTS - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] FILL = 2'd1;
   localparam logic [1:0] HOLD = 2'd2;

   logic [1:0]          state_q, state_d;
   logic [N_LIGHTS-1:0] data_q, data_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DELAY_W-1:0]  lfsr_q, lfsr_d;
   logic [DELAY_W-1:0]  delay_k_q, delay_k_d;
   logic                trig_q, trig_d;
   logic                pend_q, pend_d;
   logic                cmd_delay_q, cmd_delay_d;
   logic                lights_out_q, lights_out_d;
   logic                cmd_seq_q, cmd_seq_d;
   logic                busy_q, busy_d;
   logic                rise;

   always_comb begin
      state_d      = state_q;
      data_d       = data_q;
      cnt_d        = cnt_q;
      pend_d       = pend_q;
      delay_k_d    = delay_k_q;
      cmd_delay_d  = 1'b0;
      lights_out_d = 1'b0;
      trig_d       = bus.trigger;
      lfsr_d       = {lfsr_q[DELAY_W-2:0], ^(lfsr_q & LFSR_TAPS)};
      rise         = bus.trigger & ~trig_q;

      case (state_q)
         IDLE: begin
            // The start uses the registered pending flag, so a rise coinciding with en waits for the next en.
            if (pend_q && bus.en) begin
               state_d = FILL;
               data_d  = {{(N_LIGHTS-1){1'b0}}, 1'b1};
               cnt_d   = CNT_W'(1);
               pend_d  = 1'b0;
            end else if (rise) begin
               pend_d = 1'b1;
            end
         end
         FILL: begin
            if (bus.en) begin
               data_d = {data_q[N_LIGHTS-2:0], 1'b1};
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CNT_LAST) begin
                  state_d     = HOLD;
                  cmd_delay_d = 1'b1;
                  delay_k_d   = lfsr_q;
               end
            end
         end
         HOLD: begin
            // A done pulse alongside our own load command belongs to the previous count.
            if (bus.delay_done && !cmd_delay_q) begin
               data_d       = '0;
               cnt_d        = '0;
               lights_out_d = 1'b1;
               state_d      = AUTO_RESTART ? FILL : IDLE;
            end
         end
         default: begin
            state_d = IDLE;
            data_d  = '0;
            cnt_d   = '0;
            pend_d  = 1'b0;
         end
      endcase

      cmd_seq_d = (state_d != HOLD);
      busy_d    = (state_d == FILL) || (state_d == HOLD);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         data_q       <= '0;
         cnt_q        <= '0;
         lfsr_q       <= LFSR_SEED;
         delay_k_q    <= '0;
         trig_q       <= 1'b1;
         pend_q       <= 1'b0;
         cmd_delay_q  <= 1'b0;
         lights_out_q <= 1'b0;
         cmd_seq_q    <= 1'b1;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         data_q       <= data_d;
         cnt_q        <= cnt_d;
         lfsr_q       <= lfsr_d;
         delay_k_q    <= delay_k_d;
         trig_q       <= trig_d;
         pend_q       <= pend_d;
         cmd_delay_q  <= cmd_delay_d;
         lights_out_q <= lights_out_d;
         cmd_seq_q    <= cmd_seq_d;
         busy_q       <= busy_d;
      end
   end

   assign bus.data_out   = data_q;
   assign bus.cmd_seq    = cmd_seq_q;
   assign bus.cmd_delay  = cmd_delay_q;
   assign bus.delay_k    = delay_k_q;
   assign bus.lights_out = lights_out_q;
   assign bus.busy       = busy_q;
endmodule
